// File: rtl/imem_sync.sv
// -----------------------------------------------------------------------------
// imem_sync -- synchronous instruction memory with a registered read port.
//
// Sits between fetch (PC -> req_addr) and decode (rsp_data -> IR). After reset
// the array is optionally cleared one word per cycle (FILL) before fetches and
// loads are allowed (RUN). Fetches use a valid/ready handshake with exactly one
// cycle of latency; misaligned or out-of-range fetches return NOP_INSTR and
// flag rsp_err instead of reading the array.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    fetch request handshake, req_addr = byte address
//   rsp_valid/rsp_ready    response handshake, rsp_data = word or NOP_INSTR,
//                          rsp_err = {out_of_range, misaligned}
//   load_en/load_ready     program-load write of load_data at load_addr
//                          (bits [1:0] ignored, upper bits wrap modulo DEPTH)
//   busy                   zero-fill in progress
// -----------------------------------------------------------------------------
module imem_sync #(
  parameter int                 DEPTH     = 64,
  parameter int                 DATA_W    = 32,
  parameter int                 ZERO_FILL = 1,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  input  logic              load_en,
  output logic              load_ready,
  input  logic [31:0]       load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {ST_FILL, ST_RUN} state_t;
  localparam state_t RST_STATE = (ZERO_FILL != 0) ? ST_FILL : ST_RUN;

  state_t            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic          run;
  logic          fetch_fire;
  logic [IW-1:0] req_idx;
  logic [IW-1:0] load_idx;
  logic          fault_mis;
  logic          fault_oor;

  assign run       = (state_q == ST_RUN);
  assign req_idx   = req_addr[IW+1:2];
  assign load_idx  = load_addr[IW+1:2];
  assign fault_mis = |req_addr[1:0];
  assign fault_oor = (req_addr[31:2] >= 30'(DEPTH));

  // A load owns the cycle, and a stalled response blocks new fetches.
  assign req_ready  = run & ~load_en & (~rsp_valid_q | rsp_ready);
  assign fetch_fire = req_valid & req_ready;

  assign load_ready = run;
  assign busy       = (state_q == ST_FILL);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    if (state_q == ST_FILL) begin
      cnt_d = cnt_q + IW'(1);
      // Last word is written on this edge; RUN starts on the next one.
      if (cnt_q == IW'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end

    if (fetch_fire) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = {fault_oor, fault_mis};
      rsp_data_d  = (fault_oor | fault_mis) ? NOP_INSTR : mem[req_idx];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array has no reset; FILL clears it, loads are only taken in RUN.
  always_ff @(posedge clk) begin
    if (state_q == ST_FILL) begin
      mem[cnt_q] <= '0;
    end else if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

endmodule
